// File: rtl/riscv_bus_arbiter_if.sv
// riscv_bus_arbiter_if
//   Bundles the cache-side request/response signals and the shared memory
//   port of the bus arbiter.
//   Ports i occupy slice i of the flattened per-port vectors.
//   modport master : arbiter view. It takes the cache requests and the memory
//                    responses, and drives the grants, the readys and the
//                    memory request.
//   modport slave  : environment view, with every direction reversed.
interface riscv_bus_arbiter_if #(
  parameter int PORTS         = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [PORTS*ADDRESS_WIDTH-1:0] port_address;
  logic [PORTS-1:0]               port_read;
  logic [PORTS-1:0]               port_write;
  logic [PORTS*DATA_WIDTH-1:0]    port_out;
  logic [PORTS-1:0]               port_grant;
  logic [PORTS-1:0]               port_ready;
  logic [ADDRESS_WIDTH-1:0]       memory_address;
  logic                           memory_read;
  logic                           memory_write;
  logic [DATA_WIDTH-1:0]          memory_out;
  logic                           memory_busy;
  logic                           memory_ready;
  logic [DATA_WIDTH-1:0]          memory_in;

  modport master (
    input  port_address, port_read, port_write, port_out,
    input  memory_busy, memory_ready, memory_in,
    output port_grant, port_ready,
    output memory_address, memory_read, memory_write, memory_out
  );

  modport slave (
    output port_address, port_read, port_write, port_out,
    output memory_busy, memory_ready, memory_in,
    input  port_grant, port_ready,
    input  memory_address, memory_read, memory_write, memory_out
  );
endinterface

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter
//   N-port arbiter that shares one memory port among several cache ports.
//   It uses fixed priority or round-robin selection, and it honours memory
//   backpressure. An in-order owner FIFO holds up to DEPTH entries and routes
//   each memory response back to the port that issued it.
//   Ports:
//     clock          : system clock; all state changes on the rising edge
//     reset          : synchronous, active low
//     bus            : cache request/response and memory port (master modport)
//     outstanding    : number of requests currently in flight
//     protocol_error : sticky flag, set by a response with nothing in flight
module riscv_bus_arbiter #(
  parameter int PORTS         = 2,
  parameter int DEPTH         = 4,
  parameter int ROUND_ROBIN   = 0,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  riscv_bus_arbiter_if.master        bus,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       protocol_error
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_rr;
  logic [PW-1:0] r_owner [DEPTH];
  logic [QW-1:0] r_wptr;
  logic [QW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_perr;

  logic [PORTS-1:0] w_req;
  logic             w_any;
  logic [PW-1:0]    w_sel;
  logic             w_can_issue;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_head;
  int               w_idx;

  assign w_req = bus.port_read | bus.port_write;

  // In fixed-priority mode, the scan starts at port 0.
  // In round-robin mode, the scan starts at r_rr and wraps.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = 0; k < PORTS; k++) begin
      w_idx = (ROUND_ROBIN != 0) ? (int'(r_rr) + k) % PORTS : k;
      if (!w_any && w_req[PW'(w_idx)]) begin
        w_any = 1'b1;
        w_sel = PW'(w_idx);
      end
    end
  end

  // A response that arrives in the same cycle frees a slot. A full FIFO can
  // therefore still issue while it pops.
  assign w_can_issue = reset && !bus.memory_busy &&
                       ((r_count < CW'(DEPTH)) || bus.memory_ready);
  assign w_push      = w_can_issue && w_any;
  assign w_pop       = reset && bus.memory_ready && (r_count != '0);
  assign w_head      = r_owner[r_rptr];

  always_comb begin
    bus.port_grant = '0;
    bus.port_ready = '0;
    if (w_push) bus.port_grant[w_sel] = 1'b1;
    if (w_pop)  bus.port_ready[w_head] = 1'b1;
  end

  // When no port is granted, port 0 drives the address and data.
  // Both strobes are then low.
  always_comb begin
    bus.memory_address = bus.port_address[ADDRESS_WIDTH-1:0];
    bus.memory_out     = bus.port_out[DATA_WIDTH-1:0];
    for (int i = 1; i < PORTS; i++) begin
      if (w_push && (w_sel == PW'(i))) begin
        bus.memory_address = bus.port_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        bus.memory_out     = bus.port_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // If a port asserts both strobes, the write wins.
  assign bus.memory_write = w_push && bus.port_write[w_sel];
  assign bus.memory_read  = w_push && bus.port_read[w_sel] && !bus.port_write[w_sel];

  // The owner storage holds data only, so it needs no reset.
  always_ff @(posedge clock) begin
    if (w_push) r_owner[r_wptr] <= w_sel;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rr    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_perr  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == QW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == QW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (bus.memory_ready && (r_count == '0)) r_perr <= 1'b1;
      if ((ROUND_ROBIN != 0) && w_push)
        r_rr <= (w_sel == PW'(PORTS-1)) ? '0 : w_sel + 1'b1;
    end
  end

  assign outstanding    = r_count;
  assign protocol_error = r_perr;
endmodule
